log_8_32: RTL and testbench
===========================

# log_8_32

Receive-side byte-to-word packer in the PHY, on the `clk_4f` domain. It consumes the 8-bit byte stream produced by the 32→8 splitter, MSB byte first, four bytes per word. It reassembles 32-bit words and presents them held-stable to the `clk_f`-rate logic downstream, with an idle timeout and partial-word detection.

## Interface
- `IDLE_CYCLES`, default 4: consecutive invalid `clk_4f` cycles before `valid_out`/`data_out` are dropped; legal range 1..15.
- `clk_4f`  in  1  byte-rate clock (4× word rate); all logic on its rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `data_in`  in  8  incoming byte; sampled only when `valid`=1.
- `valid`  in  1  byte qualifier; a low cycle aborts any word in progress.
- `data_out`  out  32  last completed word; held until the next word completes or idle timeout.
- `valid_out`  out  1  high while `data_out` holds a word from an uninterrupted stream.
- `word_stb`  out  1  one-cycle pulse in the cycle `data_out` takes a new value.
- `err_partial`  out  1  one-cycle pulse when `valid` drops with 1–3 bytes collected.

## Operation
- State: byte counter `cnt` (2 bit, 0..3), accumulator `acc[23:0]` holding bytes 0–2, and idle counter `idle` (4 bit, saturating at `IDLE_CYCLES`).
- Byte lane: byte k of a word maps to `data_out[31-8k -: 8]`. Byte 0 goes to [31:24] and byte 3 to [7:0], matching the splitter's send order.
- `valid`=1, `cnt`<3:
  - store `data_in` into lane `cnt` of `acc`;
  - `cnt`←`cnt`+1;
  - `idle`←0.
- `valid`=1, `cnt`=3 (word complete):
  - `data_out`←{`acc`, `data_in`};
  - `word_stb`←1, `valid_out`←1;
  - `cnt`←0 (wrap), `acc`←0, `idle`←0.
- `valid`=0:
  - `cnt`←0 and `acc`←0;
  - if `cnt`≠0 before the edge, `err_partial`←1 for one cycle;
  - `idle`←`idle`+1, saturating at `IDLE_CYCLES`;
  - when `idle` reaches `IDLE_CYCLES`, `valid_out`←0 and `data_out`←0.
- In every cycle not listed above as setting them, `word_stb` and `err_partial` are 0.
- A single invalid cycle (`IDLE_CYCLES`>1) realigns `cnt` but keeps `valid_out`=1 and the held word. The next valid byte is treated as byte 0.
- Reset (`reset`=0 at a rising edge) overrides everything, including mid-word. Reset values: `data_out`=32'h0, `valid_out`=0, `word_stb`=0, `err_partial`=0, `cnt`=0, `acc`=0, `idle`=0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Latency: byte 3 sampled at edge N → new `data_out`, `word_stb`=1 and `valid_out`=1 visible after edge N. That is 3 edges after byte 0.
- Continuous stream: one word every 4 cycles; `data_out` is stable for 4 cycles; `word_stb` has a 1-in-4 duty cycle.
- Chained after the 32→8 splitter: a word presented at the splitter input appears on `data_out` 5 `clk_4f` edges later.
- Idle timeout: `valid_out` falls after the `IDLE_CYCLES`-th consecutive edge with `valid`=0.
- If `valid` returns to 1 on the edge where the count would have reached `IDLE_CYCLES`, `valid` wins: no timeout occurs.
- `err_partial` and a timeout may assert on the same edge; both take effect.

## Configuration
- `LOG_8_32_PARTIAL_FLUSH_EN` defined:
  - on `valid` falling with `cnt`≠0, `data_out`←{`acc`, 8'h00}, with unfilled lanes zero;
  - `word_stb` pulses together with `err_partial`;
  - `valid_out` is unchanged.
- Undefined: partial bytes are discarded; `data_out`, `valid_out` and `word_stb` are unaffected and only `err_partial` pulses.

## Structure
- Shared package `phy_pkg` holds:
  - `BYTE_W`=8, `WORD_W`=32, `BYTES_PER_WORD`=4;
  - typedef `byte_idx_t` (2 bit) for the lane counter.
- One sub-module, `phy_idle_timer`: the saturating counter with clear input and a `timeout` flag, parameterised by `IDLE_CYCLES`. The splitter side reuses it later.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `valid`=1 and `data_in`=8'hFF → all outputs 0, and no `word_stb`.
- Stream: bytes AA, BB, CC, DD then 11, 22, 33, 44, with `valid`=1 throughout:
  - `data_out`=32'hAABBCCDD after the 4th edge, then 32'h11223344 after the 8th;
  - `word_stb` pulses on exactly those two edges;
  - `valid_out` stays 1.
- Partial word: bytes 12, 34, then `valid`=0 for 1 cycle, then `valid`=1 with bytes 56, 78, 9A, BC:
  - `err_partial` pulses once;
  - next word is 32'h56789ABC;
  - with the macro, an intermediate word 32'h12340000 is flushed with `word_stb`.
- Idle timeout, `IDLE_CYCLES`=4: after one word, hold `valid`=0 → `valid_out` and `data_out` go to 0 on the 4th invalid edge. With `valid` low for only 3 cycles, `valid_out` stays 1.
- Mid-word reset: 2 bytes in, `reset`=0 for 1 cycle, then 4 bytes DE, AD, BE, EF → `data_out`=32'hDEADBEEF and no `err_partial`.
- Loopback: splitter driven with 32'hCAFEF00D → packer `data_out`=32'hCAFEF00D exactly 5 edges later.

Source files
------------

// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_pkg
// Brief    : Shared PHY widths, lane index type and byte-lane helper.
// Revision : 1.0 - initial release
// ============================================================================
package phy_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] byte_idx_t;

    // MSB bit index of byte lane k inside the 24-bit accumulator (byte 0 on top)
    function automatic int lane_msb(input byte_idx_t idx);
        return (BYTES_PER_WORD - 1 - int'(idx)) * BYTE_W - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : phy_idle_timer
// Brief    : Saturating idle counter with clear; flags the edge on which the
//            count reaches (or sits at) IDLE_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module phy_idle_timer #(
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_W       = 4
) (
    input  logic clk_4f,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam logic [CNT_W-1:0] c_limit    = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] c_prelimit = CNT_W'(IDLE_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Clear has priority, so a returning valid always cancels the timeout
    assign timeout = inc && !clear && (r_count >= c_prelimit);

endmodule
`default_nettype wire

// File: rtl/log_8_32.sv
`default_nettype none
// ============================================================================
// Module   : log_8_32
// Brief    : Receive byte-to-word packer (MSB byte first) with idle timeout
//            and partial-word detection. Optional LOG_8_32_PARTIAL_FLUSH_EN
//            flushes a zero-padded partial word on an aborted stream.
// Revision : 1.0 - initial release
// ============================================================================
module log_8_32
    import phy_pkg::*;
#(
    parameter int IDLE_CYCLES = 4
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              word_stb,
    output logic              err_partial
);

    localparam byte_idx_t c_last_lane = byte_idx_t'(BYTES_PER_WORD - 1);

    byte_idx_t                 r_cnt;
    logic [WORD_W-BYTE_W-1:0]  r_acc;
    logic [WORD_W-1:0]         r_data_out;
    logic                      r_valid_out;
    logic                      r_word_stb;
    logic                      r_err_partial;
    logic                      w_timeout;

    phy_idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (4)
    ) u_idle_timer (
        .clk_4f  (clk_4f),
        .reset   (reset),
        .clear   (valid),
        .inc     (!valid),
        .timeout (w_timeout)
    );

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_cnt         <= '0;
            r_acc         <= '0;
            r_data_out    <= '0;
            r_valid_out   <= 1'b0;
            r_word_stb    <= 1'b0;
            r_err_partial <= 1'b0;
        end else begin
            r_word_stb    <= 1'b0;
            r_err_partial <= 1'b0;
            if (valid) begin
                if (r_cnt == c_last_lane) begin
                    r_data_out  <= {r_acc, data_in};
                    r_word_stb  <= 1'b1;
                    r_valid_out <= 1'b1;
                    r_cnt       <= '0;
                    r_acc       <= '0;
                end else begin
                    r_acc[lane_msb(r_cnt) -: BYTE_W] <= data_in;
                    r_cnt <= r_cnt + 2'd1;
                end
            end else begin
                r_cnt <= '0;
                r_acc <= '0;
                if (r_cnt != '0) begin
                    r_err_partial <= 1'b1;
`ifdef LOG_8_32_PARTIAL_FLUSH_EN
                    r_data_out <= {r_acc, {BYTE_W{1'b0}}};
                    r_word_stb <= 1'b1;
`endif
                end
                // Timeout clears the held word even if a flush happened this edge
                if (w_timeout) begin
                    r_valid_out <= 1'b0;
                    r_data_out  <= '0;
                end
            end
        end
    end

    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign word_stb    = r_word_stb;
    assign err_partial = r_err_partial;

endmodule
`default_nettype wire

// File: tb/tb_log_8_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_8_32
// Brief    : Self-checking bench for log_8_32: directed vector table, splitter
//            loopback sequence and randomized stream against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_log_8_32;

    localparam int IDLE = 4;

    logic        clk_4f = 1'b0;
    logic        reset  = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        valid   = 1'b0;
    logic [31:0] data_out;
    logic        valid_out;
    logic        word_stb;
    logic        err_partial;

    int checks = 0;
    int errors = 0;

    log_8_32 #(.IDLE_CYCLES(IDLE)) dut (
        .clk_4f      (clk_4f),
        .reset       (reset),
        .data_in     (data_in),
        .valid       (valid),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .word_stb    (word_stb),
        .err_partial (err_partial)
    );

    always #5 clk_4f = ~clk_4f;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [7:0]  din;
        logic [31:0] exp_do;
        logic        exp_vo;
        logic        exp_stb;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic [31:0] e_do, input logic e_vo, input logic e_stb, input logic e_err);
        vec_t t;
        t.rst_n = r; t.vld = v; t.din = d;
        t.exp_do = e_do; t.exp_vo = e_vo; t.exp_stb = e_stb; t.exp_err = e_err;
        tbl.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_do, input logic e_vo,
                             input logic e_stb, input logic e_err);
        check({tag, ".data_out"},    data_out,           e_do);
        check({tag, ".valid_out"},   {31'd0, valid_out},   {31'd0, e_vo});
        check({tag, ".word_stb"},    {31'd0, word_stb},    {31'd0, e_stb});
        check({tag, ".err_partial"}, {31'd0, err_partial}, {31'd0, e_err});
    endtask

    // Reference model: bytes gathered in a queue, word formed when four arrive
    logic [7:0]  m_q[$];
    logic [31:0] m_do;
    logic        m_vo;
    int          m_idle;

    task automatic model_step(input logic r, input logic v, input logic [7:0] d,
                              output logic stb, output logic err);
        stb = 1'b0;
        err = 1'b0;
        if (!r) begin
            m_q.delete();
            m_do = 32'h0; m_vo = 1'b0; m_idle = 0;
        end else if (v) begin
            m_idle = 0;
            m_q.push_back(d);
            if (m_q.size() == 4) begin
                m_do = {m_q[0], m_q[1], m_q[2], m_q[3]};
                m_vo = 1'b1;
                stb  = 1'b1;
                m_q.delete();
            end
        end else begin
            err = (m_q.size() != 0);
`ifdef LOG_8_32_PARTIAL_FLUSH_EN
            if (err) begin
                m_do = 32'h0;
                foreach (m_q[i]) m_do[31 - 8*i -: 8] = m_q[i];
                stb = 1'b1;
            end
`endif
            m_q.delete();
            if (m_idle < IDLE) m_idle++;
            if (m_idle == IDLE) begin
                m_vo = 1'b0;
                m_do = 32'h0;
            end
        end
    endtask

    initial begin
        logic [31:0] part_do;
        logic        part_stb;
        logic [31:0] sp_word;
        logic        e_stb, e_err;

`ifdef LOG_8_32_PARTIAL_FLUSH_EN
        part_do  = 32'h12340000;
        part_stb = 1'b1;
`else
        part_do  = 32'h11223344;
        part_stb = 1'b0;
`endif
        // reset held with valid high
        add(0, 1, 8'hFF, 32'h0, 0, 0, 0);
        add(0, 1, 8'hFF, 32'h0, 0, 0, 0);
        // two-word stream
        add(1, 1, 8'hAA, 32'h0, 0, 0, 0);
        add(1, 1, 8'hBB, 32'h0, 0, 0, 0);
        add(1, 1, 8'hCC, 32'h0, 0, 0, 0);
        add(1, 1, 8'hDD, 32'hAABBCCDD, 1, 1, 0);
        add(1, 1, 8'h11, 32'hAABBCCDD, 1, 0, 0);
        add(1, 1, 8'h22, 32'hAABBCCDD, 1, 0, 0);
        add(1, 1, 8'h33, 32'hAABBCCDD, 1, 0, 0);
        add(1, 1, 8'h44, 32'h11223344, 1, 1, 0);
        // partial word aborted by one invalid cycle
        add(1, 1, 8'h12, 32'h11223344, 1, 0, 0);
        add(1, 1, 8'h34, 32'h11223344, 1, 0, 0);
        add(1, 0, 8'h00, part_do, 1, part_stb, 1);
        add(1, 1, 8'h56, part_do, 1, 0, 0);
        add(1, 1, 8'h78, part_do, 1, 0, 0);
        add(1, 1, 8'h9A, part_do, 1, 0, 0);
        add(1, 1, 8'hBC, 32'h56789ABC, 1, 1, 0);
        // three invalid cycles: no timeout
        add(1, 0, 8'h00, 32'h56789ABC, 1, 0, 0);
        add(1, 0, 8'h00, 32'h56789ABC, 1, 0, 0);
        add(1, 0, 8'h00, 32'h56789ABC, 1, 0, 0);
        add(1, 1, 8'h01, 32'h56789ABC, 1, 0, 0);
        add(1, 1, 8'h02, 32'h56789ABC, 1, 0, 0);
        add(1, 1, 8'h03, 32'h56789ABC, 1, 0, 0);
        add(1, 1, 8'h04, 32'h01020304, 1, 1, 0);
        // four invalid cycles: timeout on the 4th, stays dropped after
        add(1, 0, 8'h00, 32'h01020304, 1, 0, 0);
        add(1, 0, 8'h00, 32'h01020304, 1, 0, 0);
        add(1, 0, 8'h00, 32'h01020304, 1, 0, 0);
        add(1, 0, 8'h00, 32'h0, 0, 0, 0);
        add(1, 0, 8'h00, 32'h0, 0, 0, 0);
        // mid-word reset
        add(1, 1, 8'hAA, 32'h0, 0, 0, 0);
        add(1, 1, 8'hBB, 32'h0, 0, 0, 0);
        add(0, 1, 8'hFF, 32'h0, 0, 0, 0);
        add(1, 1, 8'hDE, 32'h0, 0, 0, 0);
        add(1, 1, 8'hAD, 32'h0, 0, 0, 0);
        add(1, 1, 8'hBE, 32'h0, 0, 0, 0);
        add(1, 1, 8'hEF, 32'hDEADBEEF, 1, 1, 0);

        #1;
        foreach (tbl[i]) begin
            reset   = tbl[i].rst_n;
            valid   = tbl[i].vld;
            data_in = tbl[i].din;
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].exp_do, tbl[i].exp_vo,
                      tbl[i].exp_stb, tbl[i].exp_err);
        end

        // Loopback: behavioural splitter captures the word at edge 0 and
        // emits byte k in the cycle before edge k+2, MSB byte first
        reset = 1'b0; valid = 1'b0; data_in = 8'h00;
        tick();
        reset   = 1'b1;
        sp_word = 32'hCAFEF00D;
        tick();  // edge 0: splitter loads the word
        tick();  // edge 1: splitter output register fills
        for (int k = 0; k < 4; k++) begin
            valid   = 1'b1;
            data_in = sp_word[31 - 8*k -: 8];
            tick();
            if (k == 2) check("loop.early", data_out, 32'h0);
        end
        check_all("loop", 32'hCAFEF00D, 1, 1, 0);

        // Randomized stream against the queue model
        reset = 1'b0; valid = 1'b0;
        tick();
        model_step(1'b0, 1'b0, 8'h00, e_stb, e_err);
        for (int n = 0; n < 600; n++) begin
            reset   = ($urandom_range(0, 99) != 0);
            valid   = ($urandom_range(0, 99) < 80);
            data_in = 8'($urandom);
            model_step(reset, valid, data_in, e_stb, e_err);
            tick();
            check_all($sformatf("rnd%0d", n), m_do, m_vo, e_stb, e_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
